// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling, start/stop checking and a
// one-deep valid/ready holding register for the received byte.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_FREQ = 40_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shreg_r;
    logic            sync1_r;
    logic            rx_s_r;
    logic            rx_s_d_r;
    logic            fall_s;
    logic            stop_smp_s;
    logic            offer_s;
    logic            ferr_s;

    // Two-flop synchronizer plus one delay stage for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b1;
            rx_s_r   <= 1'b1;
            rx_s_d_r <= 1'b1;
        end else begin
            sync1_r  <= rs232_rx;
            rx_s_r   <= sync1_r;
            rx_s_d_r <= rx_s_r;
        end
    end

    // Start edge detection and stop-bit sample decode.
    always_comb begin
        fall_s     = rx_s_d_r & ~rx_s_r;
        stop_smp_s = (state_r == STOP) && (cnt_r == CNT_LAST);
        offer_s    = stop_smp_s & rx_s_r;
        ferr_s     = stop_smp_s & ~rx_s_r;
    end

    // Frame FSM: bit timing, shifting and the busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            rx_busy   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, never a level.
                    if (fall_s) begin
                        state_r <= START;
                        cnt_r   <= '0;
                        rx_busy <= 1'b1;
                    end else begin
                        rx_busy <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= '0;
                        if (!rx_s_r) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        shreg_r   <= {rx_s_r, shreg_r[7:1]};
                        cnt_r     <= '0;
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    // Return to IDLE at the stop sample so a back-to-back start is caught.
                    if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        rx_busy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Holding register with overrun and framing-error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= ferr_s;
            rx_overrun   <= 1'b0;
            if (offer_s) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg_r;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled line rate (40 clocks per bit) with a
// byte scoreboard checked whenever the receiver presents a new byte.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 40_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ev_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0;
    int rise_cyc = 0, rise_prev = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
    );

    always #12.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] f);
        for (int i = 0; i < 10; i++) begin
            rs232_rx = f[i];
            wait_cyc(CPB);
        end
    endtask

    // Monitor: a new byte is present when valid rises or is reloaded right after a transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && (!pv || pr)) begin
                ev_cnt++;
                rise_prev = rise_cyc;
                rise_cyc  = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_b});
                end
            end
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_busy) busy_cnt++;
        end
        pv = rx_valid;
        pr = rx_ready;
    end

    initial begin
        int t0, e0, f0, o0, b0;
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        rx_ready = 1'b0;
        wait_cyc(4);
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_ferr", {31'h0, rx_frame_err}, 32'h0);
        check("rst_ovr", {31'h0, rx_overrun}, 32'h0);
        check("rst_busy", {31'h0, rx_busy}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(80);

        // Single frame, consumer not ready.
        exp_q.push_back(8'h31);
        e0 = ev_cnt;
        t0 = cyc;
        send(10'h262);
        wait_cyc(CPB);
        check("single_count", ev_cnt - e0, 32'd1);
        check("single_latency", rise_cyc - t0, LAT);
        check("single_valid", {31'h0, rx_valid}, 32'h1);
        check("single_ferr", ferr_cnt, 32'd0);
        check("single_ovr", ovr_cnt, 32'd0);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("consume_valid", {31'h0, rx_valid}, 32'h0);

        // Back-to-back frames, consumer always ready.
        rx_ready = 1'b1;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        e0 = ev_cnt;
        send(10'h262);
        send(10'h264);
        wait_cyc(CPB);
        rx_ready = 1'b0;
        check("b2b_count", ev_cnt - e0, 32'd2);
        check("b2b_spacing", rise_cyc - rise_prev, 10 * CPB);
        check("b2b_valid", {31'h0, rx_valid}, 32'h0);

        // Short low glitch on an idle line.
        e0 = ev_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rs232_rx = 1'b0;
        wait_cyc(HALF / 2);
        rs232_rx = 1'b1;
        wait_cyc(3 * CPB);
        check("glitch_busy_cycles", busy_cnt - b0, HALF);
        check("glitch_no_byte", ev_cnt - e0, 32'd0);
        check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

        // Framing error followed by a long low line.
        e0 = ev_cnt; f0 = ferr_cnt;
        send(10'h062);
        b0 = busy_cnt;
        wait_cyc(500);
        check("break_no_start", busy_cnt - b0, 32'd0);
        rs232_rx = 1'b1;
        wait_cyc(2 * CPB);
        check("ferr_pulses", ferr_cnt - f0, 32'd1);
        check("ferr_no_byte", ev_cnt - e0, 32'd0);
        check("ferr_busy", {31'h0, rx_busy}, 32'h0);

        // Overrun: second byte arrives while the first is still held.
        exp_q.push_back(8'h31);
        e0 = ev_cnt; o0 = ovr_cnt;
        send(10'h262);
        wait_cyc(CPB);
        send(10'h264);
        wait_cyc(CPB);
        check("ovr_pulses", ovr_cnt - o0, 32'd1);
        check("ovr_count", ev_cnt - e0, 32'd1);
        check("ovr_data", {24'h0, rx_data}, 32'h31);
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(1);
        check("ovr_drain_valid", {31'h0, rx_valid}, 32'h0);

        // Reset in the middle of data bit 4, then a clean frame.
        e0 = ev_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            rs232_rx = 1'b0;
            if (i > 0) rs232_rx = (i == 2) ? 1'b1 : 1'b0;
            wait_cyc(CPB);
        end
        rs232_rx = 1'b1;
        wait_cyc(HALF);
        rst_n = 1'b0;
        wait_cyc(4);
        check("midrst_busy", {31'h0, rx_busy}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(3 * CPB);
        check("midrst_no_byte", ev_cnt - e0, 32'd0);
        check("midrst_no_ferr", ferr_cnt - f0, 32'd0);
        check("midrst_data", {24'h0, rx_data}, 32'h0);
        exp_q.push_back(8'h32);
        send(10'h264);
        wait_cyc(CPB);
        check("post_rst_count", ev_cnt - e0, 32'd1);
        check("post_rst_valid", {31'h0, rx_valid}, 32'h1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that feeds the byte path of the `uart` block. It samples the `rs232_rx` pin as 8N1 frames, LSB first, with mid-bit sampling, and checks the start and stop bits. Each received byte goes through a one-deep valid/ready holding register to the downstream consumer (command parser / TX loopback). Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_FREQ`, default 40_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = CLK_FREQ/BAUD, integer division; 4166 at defaults. `HALF_BIT` = CLKS_PER_BIT/2 = 2083.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rs232_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; a transfer happens on any cycle with `rx_valid` & `rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `rx_overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: 2-FF chain on `rs232_rx`, both flops reset to 1, gives `rx_s`. A further flop `rx_s_d` (reset 1) is used for edge detection.
- Counters: `cnt` is a bit-period counter of width clog2(CLKS_PER_BIT). `bit_idx` is 3 bits. `shreg` is 8 bits.
- FSM states IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - Go to START when `rx_s`=0 and `rx_s_d`=1; `cnt`←0.
  - A line that is already low (break, or after a framing error) is never treated as a start bit. A rising edge must come first.
- START:
  - `cnt` counts up. At `cnt`=HALF_BIT-1, sample `rx_s`.
  - If the sample is 0, go to DATA with `cnt`←0 and `bit_idx`←0.
  - If the sample is 1 (glitch/false start), go to IDLE silently.
- DATA:
  - At `cnt`=CLKS_PER_BIT-1: `shreg`←{`rx_s`, `shreg`[7:1]}, `cnt`←0, `bit_idx`+1.
  - After the sample with `bit_idx`=7, go to STOP.
- STOP:
  - At `cnt`=CLKS_PER_BIT-1, sample `rx_s`, then go to IDLE. No wait for the end of the stop bit, so a back-to-back start edge is caught.
  - Sample 1: offer `shreg` to the holding register.
  - Sample 0: pulse `rx_frame_err`, discard the byte.
- Holding register:
  - If an offer arrives with `rx_valid`=0, or with `rx_valid`&`rx_ready` in the same cycle: `rx_data`←`shreg`, `rx_valid`←1, no overrun.
  - If an offer arrives with `rx_valid`=1 and `rx_ready`=0: keep the old data and pulse `rx_overrun`.
  - A transfer with no offer clears `rx_valid`. `rx_data` keeps its last value.
- Reset, including mid-frame: every register returns to its reset value at once and the partial byte is lost. After release, the receiver resynchronises on the next falling edge that follows a high level.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.
- All cycle counts below are measured from T, the cycle IDLE sees the falling edge on `rx_s`. The pin-to-`rx_s` delay is 2 cycles.
- START sample: T+HALF_BIT.
- Data bit k (k=0..7) sample: T+HALF_BIT+(k+1)·CLKS_PER_BIT.
- Stop sample: T+HALF_BIT+9·CLKS_PER_BIT, which is T+39577 at defaults (≈989.4 µs).
- `rx_valid`, `rx_frame_err` and `rx_overrun` are registered and change at stop sample +1.
- `rx_busy` rises at T+1 and falls at stop sample +1.
- Baud tolerance: the sample point sits at the bit centre, ±1 clock quantisation, which allows about ±4.5% total rate mismatch.
- `rx_valid` has no dependency on `rx_ready`. `rx_ready` may be tied high.

## Test plan
- Reset, then idle line for 2 µs, then frame 10'h262 (LSB first, 104166 ns/bit, 40 MHz clk) with `rx_ready`=0 → `rx_valid` rises 1 cycle after the stop sample with `rx_data`=8'h31. `rx_frame_err` and `rx_overrun` stay 0.
- Frames 10'h262 then 10'h264 back-to-back, stop-to-start gap of 0, `rx_ready`=1 → two one-cycle `rx_valid` pulses carrying 8'h31 then 8'h32, spaced exactly 10·CLKS_PER_BIT cycles apart.
- Low glitch of 1 µs on an idle line → START aborts at HALF_BIT. `rx_valid`=0, `rx_frame_err`=0, and `rx_busy` drops 1 cycle after the START sample.
- Frame 10'h062 (stop bit 0), then line held low 2 ms, then high → exactly one `rx_frame_err` pulse, no `rx_valid`, and no new start detected while the line stays low.
- Send 8'h31 then 8'h32 with `rx_ready`=0 → `rx_data` stays 8'h31 and `rx_overrun` pulses once. Then `rx_ready`=1 for one cycle → `rx_valid` clears.
- `rst_n` low for 100 ns in the middle of data bit 4, then a full 8'h32 frame → no output from the aborted frame, and the next frame yields 8'h32.
